score_keeper: RTL and testbench

Game-state and scoring controller for Pong: the producer of the 4-bit per-player scores that the score display renders. It edge-detects "ball missed" events from the ball logic and counts points in BCD range. It also sequences start, post-point serve delay and game-over, and tells the ball logic when to serve and in which direction. It sits between the ball/paddle logic and the two score display instances.

---
 rtl/score_keeper_pkg.sv | 19 +
 rtl/score_keeper_rising_edge.sv | 24 ++
 rtl/score_keeper.sv | 177 +++++++++++++++++
 tb/tb_score_keeper.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared Pong game definitions: FSM state encodings, winner codes and serve directions.
// Ball logic imports the same package so both sides agree on direction meaning.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StPlay     = 2'b01,
    StPoint    = 2'b10,
    StGameOver = 2'b11
  } state_e;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinP1   = 2'b01;
  localparam logic [1:0] WinP2   = 2'b10;

  localparam logic ServeToP1 = 1'b0;
  localparam logic ServeToP2 = 1'b1;

endpackage

// File: rtl/score_keeper_rising_edge.sv
// Registered 1-bit rising-edge detector: o_Edge pulses for one cycle after the input rises.
module score_keeper_rising_edge (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Level,
  output logic o_Edge
);

  logic prev_q;
  logic edge_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      prev_q <= i_Level;
      edge_q <= i_Level & ~prev_q;
    end
  end

  assign o_Edge = edge_q;

endmodule

// File: rtl/score_keeper.sv
// Pong game-state and scoring controller: counts points, sequences serves and game over.
// Optional winner-score blinking in GAME_OVER is enabled by defining SCORE_KEEPER_BLINK_EN.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned p_WIN_SCORE    = 9,
  parameter int unsigned p_SERVE_FRAMES = 60
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_P1_Miss,
  input  logic       i_P2_Miss,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic       o_Game_Active,
  output logic       o_Serve,
  output logic       o_Serve_Dir,
  output logic [1:0] o_Winner,
  output logic       o_P1_Blank,
  output logic       o_P2_Blank
);

  localparam logic [3:0] WinScore    = 4'(p_WIN_SCORE);
  localparam logic [7:0] ServeFrames = 8'(p_SERVE_FRAMES);

  logic start_edge, p1_miss_edge, p2_miss_edge;

  score_keeper_rising_edge u_start_edge (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Level (i_Start),
    .o_Edge  (start_edge)
  );

  score_keeper_rising_edge u_p1_miss_edge (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Level (i_P1_Miss),
    .o_Edge  (p1_miss_edge)
  );

  score_keeper_rising_edge u_p2_miss_edge (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Level (i_P2_Miss),
    .o_Edge  (p2_miss_edge)
  );

  state_e     state_q, state_d;
  logic [3:0] p1_score_q, p1_score_d;
  logic [3:0] p2_score_q, p2_score_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic       serve_q, serve_d;
  logic       dir_q, dir_d;
  logic       active_q;

  always_comb begin
    state_d     = state_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    winner_d    = winner_q;
    serve_cnt_d = serve_cnt_q;
    serve_d     = 1'b0;
    dir_d       = dir_q;
    unique case (state_q)
      StIdle, StGameOver: begin
        if (start_edge) begin
          p1_score_d = 4'd0;
          p2_score_d = 4'd0;
          winner_d   = WinNone;
          serve_d    = 1'b1;
          dir_d      = ServeToP2;
          state_d    = StPlay;
        end
      end
      StPlay: begin
        // Simultaneous misses cancel out; only a lone miss scores.
        if (p1_miss_edge && !p2_miss_edge) begin
          p2_score_d = p2_score_q + 4'd1;
          if (p2_score_d == WinScore) begin
            winner_d = WinP2;
            state_d  = StGameOver;
          end else begin
            serve_cnt_d = 8'd0;
            dir_d       = ServeToP1;
            state_d     = StPoint;
          end
        end else if (p2_miss_edge && !p1_miss_edge) begin
          p1_score_d = p1_score_q + 4'd1;
          if (p1_score_d == WinScore) begin
            winner_d = WinP1;
            state_d  = StGameOver;
          end else begin
            serve_cnt_d = 8'd0;
            dir_d       = ServeToP2;
            state_d     = StPoint;
          end
        end
      end
      StPoint: begin
        if (i_Frame_Tick) begin
          serve_cnt_d = serve_cnt_q + 8'd1;
          if (serve_cnt_d == ServeFrames) begin
            serve_d = 1'b1;
            state_d = StPlay;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      p1_score_q  <= 4'd0;
      p2_score_q  <= 4'd0;
      winner_q    <= WinNone;
      serve_cnt_q <= 8'd0;
      serve_q     <= 1'b0;
      dir_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      winner_q    <= winner_d;
      serve_cnt_q <= serve_cnt_d;
      serve_q     <= serve_d;
      dir_q       <= dir_d;
      active_q    <= (state_d == StPlay);
    end
  end

`ifdef SCORE_KEEPER_BLINK_EN
  logic [4:0] blink_cnt_q, blink_cnt_d;
  logic       p1_blank_q, p2_blank_q;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (state_d == StGameOver && state_q != StGameOver) begin
      blink_cnt_d = 5'd0;
    end else if (state_q == StGameOver && i_Frame_Tick) begin
      blink_cnt_d = blink_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      blink_cnt_q <= 5'd0;
      p1_blank_q  <= 1'b0;
      p2_blank_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      p1_blank_q  <= (state_d == StGameOver) && (winner_d == WinP1) && blink_cnt_d[4];
      p2_blank_q  <= (state_d == StGameOver) && (winner_d == WinP2) && blink_cnt_d[4];
    end
  end

  assign o_P1_Blank = p1_blank_q;
  assign o_P2_Blank = p2_blank_q;
`else
  assign o_P1_Blank = 1'b0;
  assign o_P2_Blank = 1'b0;
`endif

  assign o_P1_Score    = p1_score_q;
  assign o_P2_Score    = p2_score_q;
  assign o_Game_Active = active_q;
  assign o_Serve       = serve_q;
  assign o_Serve_Dir   = dir_q;
  assign o_Winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with default parameters (win at 9, 60-frame serve delay).
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Frame_Tick = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_P1_Miss = 1'b0;
  logic       i_P2_Miss = 1'b0;
  logic [3:0] o_P1_Score, o_P2_Score;
  logic       o_Game_Active, o_Serve, o_Serve_Dir;
  logic [1:0] o_Winner;
  logic       o_P1_Blank, o_P2_Blank;

  int  n_vec = 0;
  int  n_err = 0;
  logic saw_serve = 1'b0;

  score_keeper dut (
    .i_Clk         (clk),
    .i_Reset       (i_Reset),
    .i_Frame_Tick  (i_Frame_Tick),
    .i_Start       (i_Start),
    .i_P1_Miss     (i_P1_Miss),
    .i_P2_Miss     (i_P2_Miss),
    .o_P1_Score    (o_P1_Score),
    .o_P2_Score    (o_P2_Score),
    .o_Game_Active (o_Game_Active),
    .o_Serve       (o_Serve),
    .o_Serve_Dir   (o_Serve_Dir),
    .o_Winner      (o_Winner),
    .o_P1_Blank    (o_P1_Blank),
    .o_P2_Blank    (o_P2_Blank)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (o_Serve) saw_serve = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      i_Frame_Tick = 1'b1;
      step();
      i_Frame_Tick = 1'b0;
      step();
    end
  endtask

  // Miss pulse: after two edges the score update is visible; then release.
  task automatic p1_miss_pulse();
    i_P1_Miss = 1'b1;
    step();
    step();
    i_P1_Miss = 1'b0;
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_p1", 32'(o_P1_Score), 0);
    chk("rst_p2", 32'(o_P2_Score), 0);
    chk("rst_active", 32'(o_Game_Active), 0);
    chk("rst_serve", 32'(o_Serve), 0);
    chk("rst_dir", 32'(o_Serve_Dir), 0);
    chk("rst_winner", 32'(o_Winner), 0);
    chk("rst_blanks", 32'({o_P1_Blank, o_P2_Blank}), 0);
    i_Reset = 1'b0;
    step();

    // Start from IDLE
    i_Start = 1'b1;
    step();
    chk("start_no_early_serve", 32'(o_Serve), 0);
    step();
    chk("start_serve", 32'(o_Serve), 1);
    chk("start_dir", 32'(o_Serve_Dir), 1);
    chk("start_active", 32'(o_Game_Active), 1);
    chk("start_scores", 32'({o_P1_Score, o_P2_Score}), 0);
    chk("start_winner", 32'(o_Winner), 0);
    step();
    chk("start_serve_pulse", 32'(o_Serve), 0);
    i_Start = 1'b0;
    step();

    // P1 miss: P2 scores, POINT, serve toward P1 after 60 ticks
    p1_miss_pulse();
    chk("miss1_p2", 32'(o_P2_Score), 1);
    chk("miss1_p1", 32'(o_P1_Score), 0);
    chk("miss1_active", 32'(o_Game_Active), 0);
    step();
    i_Start = 1'b1;
    step();
    step();
    step();
    chk("point_start_ignored", 32'({o_Serve, o_Game_Active}), 0);
    i_Start = 1'b0;
    step();
    ticks(59);
    chk("point_59_ticks_active", 32'(o_Game_Active), 0);
    i_Frame_Tick = 1'b1;
    step();
    i_Frame_Tick = 1'b0;
    chk("point_serve", 32'(o_Serve), 1);
    chk("point_dir", 32'(o_Serve_Dir), 0);
    chk("point_active", 32'(o_Game_Active), 1);
    step();
    chk("point_serve_pulse", 32'(o_Serve), 0);

    // Simultaneous misses cancel
    i_P1_Miss = 1'b1;
    i_P2_Miss = 1'b1;
    step();
    step();
    step();
    chk("both_scores", 32'({o_P1_Score, o_P2_Score}), 32'h01);
    chk("both_active", 32'(o_Game_Active), 1);
    i_P1_Miss = 1'b0;
    i_P2_Miss = 1'b0;
    step();

    // P2 to 8 points, then the winning point
    for (int k = 0; k < 7; k++) begin
      p1_miss_pulse();
      step();
      ticks(60);
    end
    chk("p2_eight", 32'(o_P2_Score), 8);
    chk("p2_eight_active", 32'(o_Game_Active), 1);
    p1_miss_pulse();
    chk("win_p2", 32'(o_P2_Score), 9);
    chk("win_code", 32'(o_Winner), 32'h2);
    chk("win_active", 32'(o_Game_Active), 0);
    step();
    p1_miss_pulse();
    step();
    i_P2_Miss = 1'b1;
    step();
    step();
    i_P2_Miss = 1'b0;
    step();
    chk("gameover_hold_scores", 32'({o_P1_Score, o_P2_Score}), 32'h09);
    chk("gameover_hold_winner", 32'(o_Winner), 32'h2);
    ticks(15);
    chk("blink_p1_off", 32'(o_P1_Blank), 0);
    chk("blink_15", 32'(o_P2_Blank), 0);
    ticks(1);
`ifdef SCORE_KEEPER_BLINK_EN
    chk("blink_16", 32'(o_P2_Blank), 1);
    ticks(15);
    chk("blink_31", 32'(o_P2_Blank), 1);
    ticks(1);
    chk("blink_32", 32'(o_P2_Blank), 0);
`else
    chk("blank_tied_off", 32'(o_P2_Blank), 0);
`endif

    // Restart from GAME_OVER
    i_Start = 1'b1;
    step();
    step();
    chk("restart_serve", 32'(o_Serve), 1);
    chk("restart_dir", 32'(o_Serve_Dir), 1);
    chk("restart_scores", 32'({o_P1_Score, o_P2_Score}), 0);
    chk("restart_winner", 32'(o_Winner), 0);
    chk("restart_active", 32'(o_Game_Active), 1);
    i_Start = 1'b0;
    step();

    // P2 miss held high through the serve counts once
    i_P2_Miss = 1'b1;
    step();
    step();
    chk("held_p1", 32'(o_P1_Score), 1);
    chk("held_dir", 32'(o_Serve_Dir), 1);
    ticks(59);
    i_Frame_Tick = 1'b1;
    step();
    i_Frame_Tick = 1'b0;
    chk("held_serve", 32'({o_Serve, o_Serve_Dir}), 32'h3);
    for (int i = 0; i < 6; i++) step();
    chk("held_once", 32'(o_P1_Score), 1);
    chk("held_active", 32'(o_Game_Active), 1);
    i_P2_Miss = 1'b0;
    step();

    // Reset mid-POINT discards the pending serve
    p1_miss_pulse();
    chk("pre_reset_p2", 32'(o_P2_Score), 1);
    step();
    ticks(30);
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
    chk("midreset_scores", 32'({o_P1_Score, o_P2_Score}), 0);
    chk("midreset_active", 32'(o_Game_Active), 0);
    saw_serve = 1'b0;
    ticks(40);
    chk("midreset_no_serve", 32'(saw_serve), 0);
    chk("midreset_idle", 32'(o_Game_Active), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
